// File: rtl/matrix_c_reader.sv
// matrix_c_reader: drains result matrix C from the BRAM C read port in
// row-major order and streams each element over valid/ready, tagged with its
// (row, col) position and a last flag. A 2-entry buffer hides the 1-cycle
// BRAM read latency so the stream runs at one word per cycle when unstalled.
module matrix_c_reader #(
  parameter int ACC_WIDTH  = 32,
  parameter int M          = 4,
  parameter int P          = 4,
  parameter int ADDR_WIDTH = (M * P > 1) ? $clog2(M * P) : 1,
  localparam int ROW_W     = (M > 1) ? $clog2(M) : 1,
  localparam int COL_W     = (P > 1) ? $clog2(P) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_c_addr,
  input  logic [ACC_WIDTH-1:0]  bram_c_rdata,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_col,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // The read counter is one bit wider than the address so it can reach M*P.
  localparam int               CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(M * P);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(M * P - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(P - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] data;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic                 last;
  } entry_t;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [ROW_W-1:0]      rd_row_q, rd_row_d;
  logic [COL_W-1:0]      rd_col_q, rd_col_d;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Tags of the read currently inside the BRAM pipeline.
  logic                  in_flight_q;
  logic [ROW_W-1:0]      fl_row_q;
  logic [COL_W-1:0]      fl_col_q;
  logic                  fl_last_q;

  // 2-entry output buffer (ping-pong pointers plus occupancy).
  entry_t                buf_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  entry_t                head;
  logic                  pop;
  logic                  room;
  logic                  issue;

  // Handshake and read-issue decode; address holds when no read is issued.
  always_comb begin
    head  = buf_q[rd_ptr_q];
    pop   = (count_q != 2'd0) && out_ready;
    // A word leaving the buffer this cycle frees a slot for a new read, which
    // is what keeps the stream at one word per cycle.
    room  = ((count_q + {1'b0, in_flight_q}) != 2'd2) || pop;
    issue = (state_q == S_STREAM) && (rd_cnt_q < TOTAL) && room;
    bram_c_addr = issue ? rd_cnt_q[ADDR_WIDTH-1:0] : addr_q;
  end

  // FSM next state and row-major read position.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    rd_row_d = rd_row_q;
    rd_col_d = rd_col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_STREAM;
          rd_cnt_d = '0;
          rd_row_d = '0;
          rd_col_d = '0;
        end
      end
      S_STREAM: begin
        if (issue) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (rd_col_q == LAST_COL) begin
            rd_col_d = '0;
            rd_row_d = rd_row_q + ROW_W'(1);
          end else begin
            rd_col_d = rd_col_q + COL_W'(1);
          end
        end
        if (pop && head.last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, read counter, held address and in-flight tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      addr_q      <= '0;
      in_flight_q <= 1'b0;
      fl_row_q    <= '0;
      fl_col_q    <= '0;
      fl_last_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      addr_q      <= bram_c_addr;
      in_flight_q <= issue;
      if (issue) begin
        fl_row_q  <= rd_row_q;
        fl_col_q  <= rd_col_q;
        fl_last_q <= (rd_cnt_q == LAST_ADDR);
      end
    end
  end

  // Output buffer: capture returning BRAM data, pop on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two buffer entries are reset on purpose so out_data/out_row/
      // out_col read zero after reset; a deep storage array would not be.
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (in_flight_q) begin
        buf_q[wr_ptr_q] <= '{data: bram_c_rdata, row: fl_row_q,
                             col: fl_col_q, last: fl_last_q};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, in_flight_q} - {1'b0, pop};
    end
  end

  assign busy      = (state_q == S_STREAM);
  assign done      = (state_q == S_DONE);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head.data;
  assign out_row   = head.row;
  assign out_col   = head.col;
  assign out_last  = head.last & out_valid;

endmodule

// File: tb/tb_matrix_c_reader.sv
// Directed bench for matrix_c_reader: a 4x4 instance plus 1x1 and 2x8 instances,
// each fed by a 1-cycle-latency BRAM model with a closed-form data pattern.
module tb_matrix_c_reader;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_s = 1'b0;
  logic out_ready = 1'b1;

  always #5 clk = ~clk;

  // 4x4 instance
  logic        busy, done, out_valid, out_last;
  logic [3:0]  bram_addr;
  logic [31:0] bram_rdata, out_data;
  logic [1:0]  out_row, out_col;

  // 1x1 instance
  logic        busy11, done11, valid11, last11;
  logic [0:0]  addr11, row11, col11;
  logic [31:0] rdata11, data11;

  // 2x8 instance
  logic        busy28, done28, valid28, last28;
  logic [3:0]  addr28;
  logic [0:0]  row28;
  logic [2:0]  col28;
  logic [31:0] rdata28, data28;

  matrix_c_reader #(.ACC_WIDTH(32), .M(4), .P(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .bram_c_addr(bram_addr), .bram_c_rdata(bram_rdata), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  matrix_c_reader #(.ACC_WIDTH(32), .M(1), .P(1)) u_dut11 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy11), .done(done11),
    .bram_c_addr(addr11), .bram_c_rdata(rdata11), .out_data(data11),
    .out_row(row11), .out_col(col11), .out_last(last11),
    .out_valid(valid11), .out_ready(out_ready)
  );

  matrix_c_reader #(.ACC_WIDTH(32), .M(2), .P(8)) u_dut28 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy28), .done(done28),
    .bram_c_addr(addr28), .bram_c_rdata(rdata28), .out_data(data28),
    .out_row(row28), .out_col(col28), .out_last(last28),
    .out_valid(valid28), .out_ready(out_ready)
  );

  // BRAM models: C[i] = i * 0x01010101 (4x4), that plus 0x10 (2x8), fixed word (1x1).
  always @(posedge clk) begin
    bram_rdata <= {4{4'b0000, bram_addr}};
    rdata28    <= {4{4'b0000, addr28}} + 32'h10;
    rdata11    <= 32'hCAFEF00D;
  end

  function automatic word_t mk(input logic [31:0] d, input logic [7:0] r,
                               input logic [7:0] c, input logic l);
    mk = {d, r, c, l};
  endfunction

  function automatic word_t exp_main(input int i);
    exp_main = mk({4{8'(i)}}, 8'(i / 4), 8'(i % 4), i == 15);
  endfunction

  function automatic word_t exp_28(input int i);
    exp_28 = mk({4{8'(i)}} + 32'h10, 8'(i / 8), 8'(i % 8), i == 15);
  endfunction

  // Monitor: records handshakes and flags stall/read-ahead violations.
  word_t q_main[$];
  int    edge_main[$];
  word_t q11[$];
  word_t q28[$];
  int    cyc = 0;
  int    done_cnt = 0;
  int    done11_cnt = 0;
  int    done28_cnt = 0;
  int    stall_viol = 0;
  int    addr_viol = 0;
  int    addr_chg = 0;
  int    run_base = 0;
  logic  prev_stall = 1'b0;
  word_t held = '0;
  word_t cur;
  logic [3:0] prev_addr = 4'd0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    cur = mk(out_data, 8'(out_row), 8'(out_col), out_last);
    if (out_valid && out_ready) begin
      q_main.push_back(cur);
      edge_main.push_back(cyc);
    end
    if (valid11 && out_ready) q11.push_back(mk(data11, 8'(row11), 8'(col11), last11));
    if (valid28 && out_ready) q28.push_back(mk(data28, 8'(row28), 8'(col28), last28));
    if (done) done_cnt++;
    if (done11) done11_cnt++;
    if (done28) done28_cnt++;
    if (prev_stall && (!out_valid || cur != held)) stall_viol++;
    prev_stall = rst_n && out_valid && !out_ready;
    held = cur;
    // At most two words (next unpopped one and the one after) may be outstanding.
    if (busy && bram_addr != prev_addr) begin
      addr_chg++;
      if (int'(bram_addr) >= q_main.size() - run_base + 2) addr_viol++;
    end
    prev_addr = bram_addr;
  end

  int total = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && !done; k++) @(negedge clk);
  endtask

  task automatic wait_words(input int base, input int n);
    for (int k = 0; k < 200 && (q_main.size() - base) < n; k++) @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int base);
    check({tag, " count"}, 64'(q_main.size() - base), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < q_main.size())
        check($sformatf("%s w%0d", tag, i), 64'(q_main[base + i]), 64'(exp_main(i)));
    end
  endtask

  int t0;
  int dc0;
  int chg0;
  int b11;
  int b28;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst valid", 64'(out_valid), 64'd0);
    check("rst last", 64'(out_last), 64'd0);
    check("rst addr", 64'(bram_addr), 64'd0);
    check("rst fields", 64'({out_data, out_row, out_col}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full-rate drain with latency checks
    run_base = q_main.size();
    dc0 = done_cnt;
    t0 = cyc + 1;
    pulse_start();
    check("t1 busy", 64'(busy), 64'd1);
    check("t1 addr0", 64'(bram_addr), 64'd0);
    check("t1 valid@T", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t1 valid@T+1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t1 valid@T+2", 64'(out_valid), 64'd1);
    check("t1 first data", 64'(out_data), 64'd0);
    wait_done(200);
    check("t1 done", 64'(done), 64'd1);
    check("t1 done edge", 64'(cyc), 64'(t0 + 18));
    @(negedge clk);
    check("t1 done pulse", 64'(done), 64'd0);
    check("t1 idle", 64'(busy), 64'd0);
    check_run("t1", run_base);
    check("t1 w0 edge", 64'(edge_main[run_base]), 64'(t0 + 3));
    check("t1 w15 edge", 64'(edge_main[run_base + 15]), 64'(t0 + 18));
    check("t1 done count", 64'(done_cnt - dc0), 64'd1);

    // 2: random backpressure
    run_base = q_main.size();
    pulse_start();
    for (int k = 0; k < 400 && !done; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("t2 done", 64'(done), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check_run("t2", run_base);

    // 3: hold off for 20 cycles -> only two reads in flight
    out_ready = 1'b0;
    run_base = q_main.size();
    chg0 = addr_chg;
    pulse_start();
    repeat (20) @(negedge clk);
    check("t3 reads issued", 64'(addr_chg - chg0), 64'd2);
    check("t3 addr", 64'(bram_addr), 64'd1);
    check("t3 valid", 64'(out_valid), 64'd1);
    check("t3 head", 64'(mk(out_data, 8'(out_row), 8'(out_col), out_last)), 64'(exp_main(0)));
    out_ready = 1'b1;
    wait_done(200);
    check("t3 done", 64'(done), 64'd1);
    @(negedge clk);
    check_run("t3", run_base);

    // 4: start while busy and during done is ignored
    run_base = q_main.size();
    dc0 = done_cnt;
    pulse_start();
    wait_words(run_base, 5);
    pulse_start();
    wait_done(200);
    check("t4 done", 64'(done), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4 restart ignored", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("t4 still idle", 64'(busy), 64'd0);
    check("t4 done count", 64'(done_cnt - dc0), 64'd1);
    check_run("t4", run_base);

    // 5: asynchronous reset mid-stream, then a clean run
    run_base = q_main.size();
    dc0 = done_cnt;
    pulse_start();
    wait_words(run_base, 7);
    check("t5 streaming", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async valid", 64'(out_valid), 64'd0);
    check("t5 async busy", 64'(busy), 64'd0);
    check("t5 async done", 64'(done), 64'd0);
    check("t5 async addr", 64'(bram_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_base = q_main.size();
    pulse_start();
    wait_done(200);
    check("t5 done", 64'(done), 64'd1);
    @(negedge clk);
    check_run("t5", run_base);
    check("t5 done count", 64'(done_cnt - dc0), 64'd1);

    // 6: parameter sweep 1x1 and 2x8
    b11 = q11.size();
    b28 = q28.size();
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (40) @(negedge clk);
    check("t6 1x1 count", 64'(q11.size() - b11), 64'd1);
    if (q11.size() > b11)
      check("t6 1x1 word", 64'(q11[b11]), 64'(mk(32'hCAFEF00D, 8'd0, 8'd0, 1'b1)));
    check("t6 1x1 done", 64'(done11_cnt), 64'd1);
    check("t6 2x8 count", 64'(q28.size() - b28), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (b28 + i < q28.size())
        check($sformatf("t6 2x8 w%0d", i), 64'(q28[b28 + i]), 64'(exp_28(i)));
    end
    check("t6 2x8 done", 64'(done28_cnt), 64'd1);

    // Stream-wide properties
    check("stall stability", 64'(stall_viol), 64'd0);
    check("read-ahead bound", 64'(addr_viol), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
